pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage: computes the value loaded into the 32-bit PC register every cycle. It arbitrates between sequential fetch, branch/jump redirects, trap entry and trap return. It also holds redirects that arrive during a pipeline stall and runs a small RUN/TRAP/HALT state machine. `next_pc` drives the PC register's data input; the PC register's output returns as `pc_in`.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the next-PC controller: PC feedback, redirect sources,
// trap/halt controls and the sequencer's results.
interface pc_sequencer_if;
   logic [31:0] pc_in;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic        trap_req;
   logic [3:0]  trap_cause;
   logic        eret;
   logic        halt_req;
   logic        resume;
   logic [31:0] next_pc;
   logic        flush;
   logic [31:0] epc;
   logic [3:0]  cause;
   logic [1:0]  state;

   modport master (
      output pc_in, stall, br_taken, br_target, jmp_valid, jmp_target,
             trap_req, trap_cause, eret, halt_req, resume,
      input  next_pc, flush, epc, cause, state
   );

   modport slave (
      input  pc_in, stall, br_taken, br_target, jmp_valid, jmp_target,
             trap_req, trap_cause, eret, halt_req, resume,
      output next_pc, flush, epc, cause, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, redirects, stalled-redirect holding and
// RUN/TRAP/HALT control. Define PCSEQ_ALIGN_CHECK_EN to trap on misaligned targets.
module pc_sequencer #(
   parameter logic [31:0] ResetVec = 32'h0000_0000,
   parameter logic [31:0] TrapVec  = 32'h0000_0100
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StTrap = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [3:0]  cause_q, cause_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic [31:0] next_pc_c;
   logic        flush_c;
   logic        redir;
   logic [31:0] redir_target;
   logic        align_fault;

   always_comb begin
      state_d       = state_q;
      epc_d         = epc_q;
      cause_d       = cause_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      next_pc_c     = bus.pc_in + 32'd4;
      flush_c       = 1'b0;
      redir         = 1'b0;
      redir_target  = '0;
      align_fault   = 1'b0;

      if (state_q == StHalt) begin
         next_pc_c = bus.pc_in;
         if (bus.resume) begin
            state_d = StRun;
         end
      end else if (bus.trap_req) begin
         flush_c = 1'b1;
         if (state_q == StRun) begin
            epc_d        = bus.pc_in;
            cause_d      = bus.trap_cause;
            state_d      = StTrap;
            next_pc_c    = TrapVec;
            pend_valid_d = 1'b0;
         end else begin
            // Double fault: freeze the PC, keep the original epc.
            state_d   = StHalt;
            cause_d   = 4'hF;
            next_pc_c = bus.pc_in;
         end
      end else if (bus.stall) begin
         next_pc_c = bus.pc_in;
         // Only the oldest redirect is kept; later ones belong to younger instructions.
         if (!pend_valid_q && (bus.br_taken || bus.jmp_valid)) begin
            pend_valid_d  = 1'b1;
            pend_target_d = bus.br_taken ? bus.br_target : bus.jmp_target;
         end
      end else begin
         if (pend_valid_q) begin
            redir        = 1'b1;
            redir_target = pend_target_q;
            pend_valid_d = 1'b0;
         end else if (bus.eret && (state_q == StTrap)) begin
            redir        = 1'b1;
            redir_target = epc_q;
            state_d      = StRun;
         end else if (bus.br_taken) begin
            redir        = 1'b1;
            redir_target = bus.br_target;
         end else if (bus.jmp_valid) begin
            redir        = 1'b1;
            redir_target = bus.jmp_target;
         end

         if (redir) begin
            flush_c = 1'b1;
`ifdef PCSEQ_ALIGN_CHECK_EN
            if (redir_target[1:0] != 2'b00) begin
               align_fault = 1'b1;
               if (state_q == StRun) begin
                  epc_d        = bus.pc_in;
                  cause_d      = 4'h0;
                  state_d      = StTrap;
                  next_pc_c    = TrapVec;
                  pend_valid_d = 1'b0;
               end else begin
                  state_d   = StHalt;
                  cause_d   = 4'hF;
                  next_pc_c = bus.pc_in;
               end
            end else begin
               next_pc_c = redir_target;
            end
`else
            next_pc_c = redir_target & ~32'd3;
`endif
         end

         // Halt lands after this cycle's fetch decision; any pending redirect survives.
         if (bus.halt_req && !align_fault) begin
            state_d = StHalt;
         end
      end

      if (!rst) begin
         next_pc_c = ResetVec;
         flush_c   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StRun;
         epc_q         <= '0;
         cause_q       <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         epc_q         <= epc_d;
         cause_q       <= cause_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign bus.next_pc = next_pc_c;
   assign bus.flush   = flush_c;
   assign bus.epc     = epc_q;
   assign bus.cause   = cause_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the bench closes the PC loop itself.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_sequencer_if bus ();
   pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   int n_total = 0;
   int n_pass  = 0;
   logic [31:0] nxt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.stall      = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = '0;
      bus.jmp_valid  = 1'b0;
      bus.jmp_target = '0;
      bus.trap_req   = 1'b0;
      bus.trap_cause = '0;
      bus.eret       = 1'b0;
      bus.halt_req   = 1'b0;
      bus.resume     = 1'b0;
   endtask

   // Emulates the PC register: load next_pc at the edge.
   task automatic cycle();
      nxt = bus.next_pc;
      @(posedge clk);
      #1;
      bus.pc_in = nxt;
   endtask

   initial begin
      idle();
      bus.pc_in = 32'h1234;
      #12;
      chk("rst_next_pc", bus.next_pc, 32'h0);
      chk("rst_flush", 32'(bus.flush), 32'h0);
      chk("rst_state", 32'(bus.state), 32'h0);
      chk("rst_epc", bus.epc, 32'h0);
      chk("rst_cause", 32'(bus.cause), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bus.pc_in = 32'h0;
      #1;

      // Sequential fetch
      for (int i = 1; i <= 3; i++) begin
         chk("seq_next_pc", bus.next_pc, 32'(4 * i));
         chk("seq_flush", 32'(bus.flush), 32'h0);
         cycle();
         #1;
      end
      chk("seq_pc_in", bus.pc_in, 32'd12);
      chk("seq_state", 32'(bus.state), 32'h0);

      // Branch during stall, held until release; later redirects ignored
      bus.pc_in = 32'h40; bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h200;
      #1;
      chk("stall1_next_pc", bus.next_pc, 32'h40);
      chk("stall1_flush", 32'(bus.flush), 32'h0);
      cycle();
      bus.br_taken = 1'b0; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h500;
      #1;
      chk("stall2_next_pc", bus.next_pc, 32'h40);
      cycle();
      bus.jmp_valid = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h600;
      #1;
      chk("stall3_next_pc", bus.next_pc, 32'h40);
      cycle();
      bus.stall = 1'b0; bus.br_target = 32'h700;
      #1;
      chk("pend_next_pc", bus.next_pc, 32'h200);
      chk("pend_flush", 32'(bus.flush), 32'h1);
      cycle();
      idle();
      #1;
      chk("pend_after", bus.next_pc, 32'h204);
      chk("pend_after_flush", 32'(bus.flush), 32'h0);

      // Trap entry and return
      bus.pc_in = 32'h80; bus.trap_req = 1'b1; bus.trap_cause = 4'd3;
      #1;
      chk("trap_next_pc", bus.next_pc, 32'h100);
      chk("trap_flush", 32'(bus.flush), 32'h1);
      cycle();
      idle();
      #1;
      chk("trap_epc", bus.epc, 32'h80);
      chk("trap_cause", 32'(bus.cause), 32'h3);
      chk("trap_state", 32'(bus.state), 32'h1);
      chk("trap_seq", bus.next_pc, 32'h104);
      cycle();
      bus.eret = 1'b1;
      #1;
      chk("eret_next_pc", bus.next_pc, 32'h80);
      chk("eret_flush", 32'(bus.flush), 32'h1);
      cycle();
      idle();
      #1;
      chk("eret_state", 32'(bus.state), 32'h0);
      chk("eret_seq", bus.next_pc, 32'h84);

      // Double fault, frozen HALT, resume
      bus.trap_req = 1'b1; bus.trap_cause = 4'd5;
      #1;
      cycle();
      bus.trap_cause = 4'd7;
      #1;
      chk("dbl_state_pre", 32'(bus.state), 32'h1);
      chk("dbl_next_pc", bus.next_pc, 32'h100);
      chk("dbl_flush", 32'(bus.flush), 32'h1);
      cycle();
      idle();
      #1;
      chk("dbl_state", 32'(bus.state), 32'h2);
      chk("dbl_cause", 32'(bus.cause), 32'hF);
      chk("dbl_epc", bus.epc, 32'h80);
      for (int i = 0; i < 5; i++) begin
         bus.br_taken = 1'b1; bus.br_target = 32'h300; bus.trap_req = 1'b1;
         #1;
         chk("halt_freeze", bus.next_pc, 32'h100);
         chk("halt_flush", 32'(bus.flush), 32'h0);
         cycle();
      end
      idle();
      bus.resume = 1'b1;
      #1;
      chk("resume_next_pc", bus.next_pc, 32'h100);
      chk("resume_state_pre", 32'(bus.state), 32'h2);
      cycle();
      idle();
      #1;
      chk("resume_state", 32'(bus.state), 32'h0);
      chk("resume_seq", bus.next_pc, 32'h104);

      // Wrap and branch-over-jump priority
      bus.pc_in = 32'hFFFF_FFFC;
      #1;
      chk("wrap", bus.next_pc, 32'h0);
      bus.br_taken = 1'b1; bus.br_target = 32'h300;
      bus.jmp_valid = 1'b1; bus.jmp_target = 32'h400;
      #1;
      chk("br_over_jmp", bus.next_pc, 32'h300);
      chk("br_over_jmp_flush", 32'(bus.flush), 32'h1);

      // Halt request: this cycle's redirect still goes out
      idle();
      bus.pc_in = 32'h300; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h400; bus.halt_req = 1'b1;
      #1;
      chk("halt_req_next_pc", bus.next_pc, 32'h400);
      cycle();
      idle();
      #1;
      chk("halt_req_state", 32'(bus.state), 32'h2);
      chk("halt_req_hold", bus.next_pc, 32'h400);
      bus.resume = 1'b1;
      #1;
      cycle();
      idle();
      #1;
      chk("halt_exit_state", 32'(bus.state), 32'h0);

      // eret outside TRAP does nothing
      bus.eret = 1'b1;
      #1;
      chk("eret_run_next_pc", bus.next_pc, 32'h404);
      chk("eret_run_flush", 32'(bus.flush), 32'h0);
      idle();

      // Reset mid-operation drops the pending redirect
      bus.pc_in = 32'h500; bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h600;
      #1;
      cycle();
      rst = 1'b0;
      #1;
      chk("midrst_next_pc", bus.next_pc, 32'h0);
      rst = 1'b1;
      idle();
      bus.pc_in = 32'h0;
      #1;
      chk("midrst_no_pend", bus.next_pc, 32'h4);
      chk("midrst_flush", 32'(bus.flush), 32'h0);

      // Misaligned branch target
      bus.pc_in = 32'h10; bus.br_taken = 1'b1; bus.br_target = 32'h202;
      #1;
`ifdef PCSEQ_ALIGN_CHECK_EN
      chk("align_next_pc", bus.next_pc, 32'h100);
      cycle();
      idle();
      #1;
      chk("align_cause", 32'(bus.cause), 32'h0);
      chk("align_epc", bus.epc, 32'h10);
      chk("align_state", 32'(bus.state), 32'h1);
`else
      chk("align_next_pc", bus.next_pc, 32'h200);
      chk("align_flush", 32'(bus.flush), 32'h1);
      cycle();
      idle();
      #1;
      chk("align_state", 32'(bus.state), 32'h0);
      chk("align_seq", bus.next_pc, 32'h204);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
